mips_timer: RTL
===============

Name: mips_timer

Overview:
- Memory-mapped countdown timer peripheral on the MIPS system bridge; raises the hardware interrupt line that feeds CP0's HWInt input (typically HWInt[0]).
- CPU programs it through sw/lw via the bridge; the ISR acknowledges by rewriting CTRL or PRESET.
- Two modes: one-shot with a held IRQ, and auto-reload with a one-cycle IRQ pulse.

Parameters:
- BASE_SEL, 2'b00: unused address-decode hook; the bridge drives WE only when the timer is selected. Kept for bridge uniformity.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- Addr  input  2  word offset, byte address [3:2]: 0 CTRL, 1 PRESET, 2 COUNT, 3 PRESCALE/reserved
- WE  input  1  write enable, sampled on posedge clk
- dataIn  input  32  write data
- dataOut  output  32  combinational read data for Addr
- IRQ  output  1  interrupt request to CP0 HWInt

Behaviour:
- Registers:
  - CTRL[3:0]: [0] En, [2:1] Mode (00 one-shot, 01 auto-reload, others as 00), [3] IM (IRQ mask). Bits [31:4] read 0.
  - PRESET[31:0] is read/write. COUNT[31:0] is read-only; writes to COUNT are ignored.
- Reset (reset_n low, async): CTRL, PRESET, COUNT, irq_flag = 0; state IDLE; IRQ = 0; dataOut follows the zeroed registers.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: En=1 -> LOAD, else stay.
  - LOAD: COUNT <= PRESET -> CNT.
  - CNT: En=0 -> IDLE, COUNT holds. Else COUNT==0 -> INT. Else COUNT <= COUNT-1.
  - INT: irq_flag <= 1 -> IDLE. If Mode==00, En <= 0.
- irq_flag:
  - Mode 01: cleared on the edge after it is set (one-cycle pulse).
  - Mode 00: held until a CTRL or PRESET write.
  - Any CTRL or PRESET write clears irq_flag on that edge.
- IRQ = irq_flag & CTRL.IM, registered output, no combinational path from dataIn.
- Latency:
  - En written at edge t with PRESET=N: COUNT=N after edge t+2; reaches 0 after edge t+2+N; INT after t+3+N; IRQ high after t+4+N.
  - Auto-reload period: N+4 cycles.
- Boundary conditions:
  - PRESET=0 -> INT directly from CNT; period 4.
  - COUNT never wraps below 0. 32-bit arithmetic, PRESET up to 0xFFFFFFFF.
- Simultaneous events:
  - Bus write in the same cycle as the INT-state auto-clear of En: the bus write wins.
  - PRESET write during CNT does not disturb COUNT; it takes effect at the next LOAD.
  - Clearing En mid-count freezes COUNT. Re-enabling goes through LOAD, so COUNT restarts from PRESET.
- Async reset mid-count: immediate return to reset values, no IRQ glitch.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - Addr 3 is a R/W 16-bit PRESCALE register, reset 0.
  - A 16-bit divider counter reloads from PRESCALE. CNT decrements COUNT only on divider terminal, i.e. every PRESCALE+1 cycles.
  - Divider resets in LOAD.
  - Auto-reload period: (N+1)*(PRESCALE+1)+3.
- Undefined:
  - Addr 3 reads 0; writes are ignored.
  - Decrement every cycle; behaviour identical to PRESCALE=0.

Test Plan:
- Reset: assert reset_n=0 mid-count (COUNT=5) -> COUNT, CTRL, IRQ read 0 immediately; state IDLE after release.
- One-shot: PRESET=10, CTRL=0x9 (En, mode 00, IM) -> IRQ rises 14 cycles after the CTRL write edge and stays high. En reads 0. Writing CTRL=0x9 drops IRQ next edge and restarts the count.
- Auto-reload: PRESET=3, CTRL=0xB -> IRQ one-cycle pulses every 7 cycles for ≥5 periods. COUNT reads sequence 3,2,1,0.
- Mask and pause:
  - CTRL=0x1 (IM=0), PRESET=2 -> no IRQ.
  - Mid-count write CTRL=0x0 -> COUNT frozen for 20 cycles. Re-enable -> COUNT reloads to PRESET.
- Edge cases:
  - PRESET=0, mode 01 -> 4-cycle period.
  - PRESET write during CNT leaves the current count unchanged.
  - CTRL write in the INT cycle -> written En preserved.
- With TIMER_PRESCALE_EN, PRESCALE=2, PRESET=3, mode 01 -> period 15 cycles. Without the macro, Addr 3 reads 0 after a write of 0x5.

Source files
------------

// File: rtl/mips_timer.sv
`default_nettype none
// mips_timer: memory-mapped countdown timer with one-shot (held IRQ) and auto-reload (pulsed IRQ) modes.
// Optional macro TIMER_PRESCALE_EN adds a 16-bit PRESCALE register at Addr 3 that divides the count rate.
module mips_timer #(
  parameter logic [1:0] BASE_SEL = 2'b00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic        en;
  logic        auto_reload;
  logic        im;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        tick;

  // The bridge already qualifies WE with the select, so BASE_SEL has no decode role here.
  logic        unused_base_sel;
  assign unused_base_sel = ^BASE_SEL;

  assign en          = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign im          = ctrl[3];
  assign wr_ctrl     = WE && (Addr == 2'd0);
  assign wr_preset   = WE && (Addr == 2'd1);

`ifdef TIMER_PRESCALE_EN
  logic [15:0] prescale;
  logic [15:0] div_cnt;
  logic        wr_prescale;

  assign wr_prescale = WE && (Addr == 2'd3);
  assign tick        = (div_cnt == 16'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale <= 16'd0;
      div_cnt  <= 16'd0;
    end else begin
      if (wr_prescale) begin
        prescale <= dataIn[15:0];
      end
      if (state == S_LOAD) begin
        div_cnt <= prescale;
      end else if (state == S_CNT && en) begin
        div_cnt <= tick ? prescale : div_cnt - 16'd1;
      end
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (en) state_nx = S_LOAD;
      S_LOAD: state_nx = S_CNT;
      S_CNT: begin
        if (!en) begin
          state_nx = S_IDLE;
        end else if (tick && count == 32'd0) begin
          state_nx = S_INT;
        end
      end
      S_INT:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // A bus write to CTRL takes priority over the one-shot auto-clear of En.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl   <= 4'd0;
      preset <= 32'd0;
    end else begin
      if (wr_ctrl) begin
        ctrl <= dataIn[3:0];
      end else if (state == S_INT && !auto_reload) begin
        ctrl[0] <= 1'b0;
      end
      if (wr_preset) begin
        preset <= dataIn;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 32'd0;
    end else if (state == S_LOAD) begin
      count <= preset;
    end else if (state == S_CNT && en && tick && count != 32'd0) begin
      count <= count - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_flag <= 1'b0;
    end else if (wr_ctrl || wr_preset) begin
      irq_flag <= 1'b0;
    end else if (state == S_INT) begin
      irq_flag <= 1'b1;
    end else if (irq_flag && auto_reload) begin
      irq_flag <= 1'b0;
    end
  end

  assign IRQ = irq_flag & im;

  always_comb begin
    dataOut = 32'd0;
    case (Addr)
      2'd0: dataOut = {28'd0, ctrl};
      2'd1: dataOut = preset;
      2'd2: dataOut = count;
`ifdef TIMER_PRESCALE_EN
      2'd3: dataOut = {16'd0, prescale};
`endif
      default: dataOut = 32'd0;
    endcase
  end

endmodule
`default_nettype wire
